// File: rtl/riscv_aes_ctx_regs.sv
// rtl/riscv_aes_ctx_regs.sv - AES context register bank and one-operation sequencer
// Optional: RISCV_AES_CHAIN_EN copies the acknowledged result back into the state words.
module riscv_aes_ctx_regs #(
   parameter int DATA_WIDTH      = 32,
   parameter int NUM_STATE_WORDS = 4,
   parameter int NUM_KEY_WORDS   = 8,
   parameter int NUM_KEY_SLOTS   = 2,
   parameter int ADDR_WIDTH      = $clog2(NUM_KEY_WORDS*NUM_KEY_SLOTS)
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  test_en_i,
   input  logic [1:0]                            sel_i,
   input  logic [ADDR_WIDTH-1:0]                 waddr_i,
   input  logic [DATA_WIDTH-1:0]                 wdata_i,
   input  logic                                  wen_i,
   input  logic                                  cmd_en_i,
   input  logic                                  start_i,
   output logic [NUM_STATE_WORDS*DATA_WIDTH-1:0] state_o,
   output logic [NUM_KEY_WORDS*DATA_WIDTH-1:0]   key_o,
   output logic [1:0]                            key_len_o,
   output logic [DATA_WIDTH-1:0]                 wb_addr_o,
   output logic                                  start_o,
   output logic                                  busy_o,
   input  logic                                  core_done_i,
   input  logic [NUM_STATE_WORDS*DATA_WIDTH-1:0] core_result_i,
   output logic                                  result_valid_o,
   output logic [NUM_STATE_WORDS*DATA_WIDTH-1:0] result_o,
   input  logic                                  result_ack_i,
   output logic                                  err_o
);

   localparam int SLOT_W = (NUM_KEY_SLOTS > 1) ? $clog2(NUM_KEY_SLOTS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_DONE} state_t;

   state_t                                 r_state;
   state_t                                 w_next;
   logic [DATA_WIDTH-1:0]                  r_st  [NUM_STATE_WORDS];
   logic [DATA_WIDTH-1:0]                  r_key [NUM_KEY_SLOTS][NUM_KEY_WORDS];
   logic [DATA_WIDTH-1:0]                  r_wb;
   logic [NUM_STATE_WORDS*DATA_WIDTH-1:0]  r_result;
   logic [1:0]                             r_klen, r_klen_pend;
   logic [SLOT_W-1:0]                      r_slot, r_slot_pend;
   logic                                   r_err;

   logic              w_busy, w_ctrl_wr, w_data_wr, w_err_set;
   logic [1:0]        w_klen_new, w_klen_sel;
   logic [SLOT_W-1:0] w_slot_new, w_slot_sel;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (cmd_en_i && start_i) w_next = S_START;
         S_START: w_next = S_BUSY;
         S_BUSY:  if (core_done_i) w_next = S_DONE;
         S_DONE:  if (result_ack_i) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (test_en_i) w_next = S_IDLE;
   end

   assign w_busy     = (r_state != S_IDLE);
   assign w_ctrl_wr  = wen_i && (sel_i == 2'd3);
   assign w_data_wr  = wen_i && (sel_i != 2'd3) && !w_busy;
   assign w_err_set  = (cmd_en_i && start_i && w_busy) || (wen_i && (sel_i != 2'd3) && w_busy);
   assign w_klen_new = (wdata_i[1:0] == 2'd3) ? 2'd2 : wdata_i[1:0];

   generate
      if (NUM_KEY_SLOTS > 1) begin : g_slot
         assign w_slot_new = wdata_i[2 +: SLOT_W];
      end else begin : g_noslot
         assign w_slot_new = '0;
      end
   endgenerate

   // Control writes always land in the pending copy; the active copy only follows it while idle.
   assign w_klen_sel = w_ctrl_wr ? w_klen_new : r_klen_pend;
   assign w_slot_sel = w_ctrl_wr ? w_slot_new : r_slot_pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_err       <= 1'b0;
         r_wb        <= '0;
         r_result    <= '0;
         r_klen      <= '0;
         r_klen_pend <= '0;
         r_slot      <= '0;
         r_slot_pend <= '0;
         for (int i = 0; i < NUM_STATE_WORDS; i++) r_st[i] <= '0;
         for (int s = 0; s < NUM_KEY_SLOTS; s++)
            for (int w = 0; w < NUM_KEY_WORDS; w++) r_key[s][w] <= '0;
      end else begin
         r_state <= w_next;
         if (w_err_set)      r_err <= 1'b1;
         else if (w_ctrl_wr) r_err <= 1'b0;
         r_klen_pend <= w_klen_sel;
         r_slot_pend <= w_slot_sel;
         if (r_state == S_IDLE || w_next == S_IDLE) begin
            r_klen <= w_klen_sel;
            r_slot <= w_slot_sel;
         end
         if (w_data_wr && sel_i == 2'd2) r_wb <= wdata_i;
         for (int s = 0; s < NUM_KEY_SLOTS; s++)
            for (int w = 0; w < NUM_KEY_WORDS; w++)
               if (w_data_wr && sel_i == 2'd1 && int'(waddr_i) == s*NUM_KEY_WORDS + w)
                  r_key[s][w] <= wdata_i;
         if (r_state == S_BUSY && core_done_i) r_result <= core_result_i;
         for (int i = 0; i < NUM_STATE_WORDS; i++) begin
            if (test_en_i)
               r_st[i] <= '1;
`ifdef RISCV_AES_CHAIN_EN
            else if (r_state == S_DONE && result_ack_i)
               r_st[i] <= r_result[i*DATA_WIDTH +: DATA_WIDTH];
`endif
            else if (w_data_wr && sel_i == 2'd0 && int'(waddr_i) == i)
               r_st[i] <= wdata_i;
         end
      end
   end

   generate
      for (genvar i = 0; i < NUM_STATE_WORDS; i++) begin : g_st
         assign state_o[i*DATA_WIDTH +: DATA_WIDTH] = r_st[i];
      end
      for (genvar w = 0; w < NUM_KEY_WORDS; w++) begin : g_key
         assign key_o[w*DATA_WIDTH +: DATA_WIDTH] = r_key[r_slot][w];
      end
   endgenerate

   assign key_len_o      = r_klen;
   assign wb_addr_o      = r_wb;
   assign start_o        = (r_state == S_START);
   assign busy_o         = w_busy;
   assign result_valid_o = (r_state == S_DONE);
   assign result_o       = r_result;
   assign err_o          = r_err;

endmodule

// File: tb/tb_riscv_aes_ctx_regs.sv
// tb/tb_riscv_aes_ctx_regs.sv - self-checking bench with behavioural model for riscv_aes_ctx_regs
module tb_riscv_aes_ctx_regs;
   localparam int DW = 32, NS = 4, NKW = 8, NSL = 2, AW = 4;

   logic              clk = 1'b0;
   logic              rst_n, test_en, wen, cmd_en, start, core_done, result_ack;
   logic [1:0]        sel;
   logic [AW-1:0]     waddr;
   logic [DW-1:0]     wdata;
   logic [NS*DW-1:0]  core_result, state_o, result_o;
   logic [NKW*DW-1:0] key_o;
   logic [1:0]        key_len_o;
   logic [DW-1:0]     wb_addr_o;
   logic              start_o, busy_o, result_valid_o, err_o;

   always #5 clk = ~clk;

   riscv_aes_ctx_regs dut (
      .clk(clk), .rst_n(rst_n), .test_en_i(test_en), .sel_i(sel), .waddr_i(waddr),
      .wdata_i(wdata), .wen_i(wen), .cmd_en_i(cmd_en), .start_i(start),
      .state_o(state_o), .key_o(key_o), .key_len_o(key_len_o), .wb_addr_o(wb_addr_o),
      .start_o(start_o), .busy_o(busy_o), .core_done_i(core_done),
      .core_result_i(core_result), .result_valid_o(result_valid_o), .result_o(result_o),
      .result_ack_i(result_ack), .err_o(err_o)
   );

   int n_tests = 0, n_fail = 0;

   // Model: phase 0 idle, 1 start pulse, 2 waiting for core, 3 result held
   logic [DW-1:0]    m_st [NS];
   logic [DW-1:0]    m_key [NSL][NKW];
   logic [DW-1:0]    m_wb;
   logic [NS*DW-1:0] m_res;
   logic [1:0]       m_kl, m_kl_p;
   int               m_slot, m_slot_p, m_ph;
   logic             m_err;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NS; i++) m_st[i] = '0;
      for (int s = 0; s < NSL; s++) for (int w = 0; w < NKW; w++) m_key[s][w] = '0;
      m_wb = '0; m_res = '0; m_kl = 0; m_kl_p = 0; m_slot = 0; m_slot_p = 0; m_ph = 0; m_err = 0;
   endtask

   task automatic model_step();
      int  nph;
      logic busy;
      logic [1:0] kl;
      busy = (m_ph != 0);
      nph  = m_ph;
      if (wen && sel == 3) m_err = 1'b0;
      if ((cmd_en && start && busy) || (wen && sel != 3 && busy)) m_err = 1'b1;
      if (wen && !busy) begin
         if (sel == 0 && waddr < NS) m_st[waddr] = wdata;
         if (sel == 1 && waddr / NKW < NSL) m_key[waddr / NKW][waddr % NKW] = wdata;
         if (sel == 2) m_wb = wdata;
      end
      if (wen && sel == 3) begin
         kl = wdata[1:0];
         if (kl == 3) kl = 2;
         m_kl_p   = kl;
         m_slot_p = (wdata >> 2) % NSL;
      end
      if (m_ph == 0 && cmd_en && start) nph = 1;
      else if (m_ph == 1) nph = 2;
      else if (m_ph == 2 && core_done) begin nph = 3; m_res = core_result; end
      else if (m_ph == 3 && result_ack) begin
         nph = 0;
`ifdef RISCV_AES_CHAIN_EN
         for (int i = 0; i < NS; i++) m_st[i] = m_res[i*DW +: DW];
`endif
      end
      if (test_en) begin
         nph = 0;
         for (int i = 0; i < NS; i++) m_st[i] = '1;
      end
      if (m_ph == 0 || nph == 0) begin m_kl = m_kl_p; m_slot = m_slot_p; end
      m_ph = nph;
   endtask

   task automatic check_all();
      logic [255:0] es, ek;
      es = '0; ek = '0;
      for (int i = 0; i < NS; i++) es[i*DW +: DW] = m_st[i];
      for (int w = 0; w < NKW; w++) ek[w*DW +: DW] = m_key[m_slot][w];
      chk("state_o", 256'(state_o), es);
      chk("key_o", 256'(key_o), ek);
      chk("key_len_o", 256'(key_len_o), 256'(m_kl));
      chk("wb_addr_o", 256'(wb_addr_o), 256'(m_wb));
      chk("start_o", 256'(start_o), 256'(m_ph == 1));
      chk("busy_o", 256'(busy_o), 256'(m_ph != 0));
      chk("result_valid_o", 256'(result_valid_o), 256'(m_ph == 3));
      chk("result_o", 256'(result_o), 256'(m_res));
      chk("err_o", 256'(err_o), 256'(m_err));
   endtask

   task automatic idle_in();
      test_en = 0; wen = 0; sel = 0; waddr = '0; wdata = '0; cmd_en = 0; start = 0;
      core_done = 0; core_result = '0; result_ack = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic wr(input logic [1:0] s, input int a, input logic [DW-1:0] d);
      wen = 1; sel = s; waddr = AW'(a); wdata = d;
      cyc();
      idle_in();
   endtask

   task automatic go();
      cmd_en = 1; start = 1;
      cyc();
      idle_in();
   endtask

   task automatic async_reset();
      #2 rst_n = 0;
      #1;
      model_reset();
      chk("rst_busy", 256'(busy_o), 256'(0));
      chk("rst_rvalid", 256'(result_valid_o), 256'(0));
      chk("rst_start", 256'(start_o), 256'(0));
      check_all();
      @(negedge clk) rst_n = 1;
   endtask

   logic [NS*DW-1:0] lit_state;

   initial begin
      idle_in();
      rst_n = 0;
      model_reset();
      #12;
      check_all();
      chk("reset_key_len", 256'(key_len_o), 256'(0));
      chk("reset_busy", 256'(busy_o), 256'(0));
      @(negedge clk) rst_n = 1;

      lit_state = 128'hCCDDEEFF8899AABB4455667700112233;
      wr(0, 0, 32'h00112233);
      wr(0, 1, 32'h44556677);
      wr(0, 2, 32'h8899AABB);
      wr(0, 3, 32'hCCDDEEFF);
      go();
      chk("start_pulse", 256'(start_o), 256'(1));
      chk("busy_with_start", 256'(busy_o), 256'(1));
      chk("state_lit", 256'(state_o), 256'(lit_state));
      cyc();
      chk("start_one_cycle", 256'(start_o), 256'(0));

      wen = 1; sel = 0; waddr = '0; wdata = 32'hDEADBEEF; cmd_en = 1; start = 1;
      cyc();
      idle_in();
      chk("busy_write_dropped", 256'(state_o), 256'(lit_state));
      chk("busy_err_set", 256'(err_o), 256'(1));
      wr(3, 0, 32'h5);
      chk("ctrl_clears_err", 256'(err_o), 256'(0));
      chk("ctrl_shadowed", 256'(key_len_o), 256'(0));

      core_done = 1; core_result = {4{32'hA5A5A5A5}};
      cyc();
      idle_in();
      chk("rvalid_rise", 256'(result_valid_o), 256'(1));
      chk("result_lit", 256'(result_o), 256'({4{32'hA5A5A5A5}}));
      cyc();
      chk("rvalid_held", 256'(result_valid_o), 256'(1));
      result_ack = 1;
      cyc();
      idle_in();
      chk("ack_busy_fall", 256'(busy_o), 256'(0));
      chk("ack_rvalid_fall", 256'(result_valid_o), 256'(0));
      chk("shadow_applied", 256'(key_len_o), 256'(1));
`ifdef RISCV_AES_CHAIN_EN
      chk("chain_state", 256'(state_o), 256'({4{32'hA5A5A5A5}}));
`else
      chk("nochain_state", 256'(state_o), 256'(lit_state));
`endif

      for (int i = 0; i < 6; i++) wr(1, 8 + i, 32'h1000 + i);
      chk("key_slot1", 256'(key_o), {64'h0, 32'h1005, 32'h1004, 32'h1003, 32'h1002, 32'h1001, 32'h1000});
      wr(3, 0, 32'h3);
      chk("key_len_3_as_2", 256'(key_len_o), 256'(2));
      chk("key_slot0", 256'(key_o), 256'(0));

      go();
      cyc();
      async_reset();
      go();
      chk("start_after_reset", 256'(start_o), 256'(1));
      cyc();
      core_done = 1; core_result = {$urandom, $urandom, $urandom, $urandom};
      cyc();
      idle_in();
      result_ack = 1; cmd_en = 1; start = 1;
      cyc();
      idle_in();
      chk("ack_start_err", 256'(err_o), 256'(1));
      chk("ack_start_idle", 256'(busy_o), 256'(0));

      for (int c = 0; c < 3000; c++) begin
         wen         = ($urandom_range(0, 3) == 0);
         sel         = 2'($urandom_range(0, 3));
         waddr       = AW'($urandom_range(0, 15));
         wdata       = $urandom;
         cmd_en      = ($urandom_range(0, 7) != 0);
         start       = ($urandom_range(0, 5) == 0);
         core_done   = ($urandom_range(0, 3) == 0);
         core_result = {$urandom, $urandom, $urandom, $urandom};
         result_ack  = ($urandom_range(0, 2) == 0);
         test_en     = ($urandom_range(0, 40) == 0);
         cyc();
         if (c % 700 == 350) begin
            idle_in();
            async_reset();
         end
      end
      idle_in();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
